riscv_aes_fetch: RTL and testbench
==================================

Name: riscv_aes_fetch

Overview:
- Read-side companion of the AES write-back unit. On a start pulse it halts the core and issues NUM_WORDS sequential 32-bit word reads on a PULP req/gnt/rvalid data-memory port.
- It assembles the returned words into one block and presents the block to the AES core with a single-cycle valid pulse, then releases the halt.
- Word ordering is the mirror of write-back: word i, at address base+4*i, lands in data_out[i*32 +: 32].

Parameters:
- NUM_WORDS, 4, number of 32-bit words per block; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_aes_fetch_in  input  1  start request; sampled only in IDLE.
- address_in  input  32  block base address; latched at start; bits [1:0] forced to 0.
- mem_req_out  output  1  memory read request.
- mem_addr_out  output  32  word address of the current request.
- mem_gnt_in  input  1  request accepted this cycle.
- mem_rvalid_in  input  1  read data valid; responses return in request order.
- mem_rdata_in  input  32  read data.
- halt_en_out  output  1  core halt while a fetch is in progress.
- data_valid_out  output  1  one-cycle pulse; data_out is complete.
- data_out  output  32*NUM_WORDS  assembled block; held until overwritten by the next fetch.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; base 0.
- States: IDLE, REQ, WAIT_RSP, DONE. All transitions are registered.
- IDLE:
  - halt_en_out=0, mem_req_out=0.
  - On start_aes_fetch_in=1: latch base = {address_in[31:2],2'b00}; clear req_cnt and rsp_cnt; go to REQ.
- REQ:
  - mem_req_out=1; mem_addr_out = base + 4*req_cnt, modulo 2^32.
  - mem_req_out and mem_addr_out are driven from registers only; there is no combinational path from mem_gnt_in.
  - mem_req_out and mem_addr_out hold stable until mem_gnt_in=1.
  - On grant: req_cnt increments. If req_cnt == NUM_WORDS-1 at grant, go to WAIT_RSP. Otherwise the next address is issued the following cycle (back-to-back requests allowed).
- Response capture (REQ and WAIT_RSP):
  - mem_rvalid_in=1 writes mem_rdata_in to slot rsp_cnt and increments rsp_cnt.
  - rvalid may coincide with a later request's grant; both are handled in that cycle.
  - rvalid never arrives in the same cycle as its own grant.
  - When the NUM_WORDS-th response is captured, go to DONE.
- WAIT_RSP: mem_req_out=0; capture remaining responses.
- DONE: data_valid_out=1 for exactly this cycle; halt_en_out=1; next state IDLE.
- halt_en_out is 1 in every cycle the state is REQ, WAIT_RSP or DONE, and 0 in IDLE.
- Latency, zero-wait memory (gnt in the first request cycle, rvalid one cycle after gnt):
  - start sampled in cycle 0; requests in cycles 1..NUM_WORDS.
  - data_valid_out in cycle NUM_WORDS+2; halt_en_out=0 from cycle NUM_WORDS+3.
- Boundary conditions:
  - start_aes_fetch_in outside IDLE is ignored.
  - mem_rvalid_in in IDLE or DONE is ignored (stale responses after reset).
  - rvalid when rsp_cnt == NUM_WORDS is ignored.
  - rsp_cnt never exceeds req_cnt under a legal memory; there is no outstanding-request limit beyond NUM_WORDS.
  - data_out is only modified by response capture; partial updates are visible during a fetch, and consumers use data_valid_out.
  - Counter width: $clog2(NUM_WORDS+1).
  - Address wrap: the address add is 32-bit with carry-out discarded.
- Reset mid-operation: immediate return to the reset values listed above. No pulse on data_valid_out; the aborted fetch is not resumed.

Test Plan:
- Zero-wait fetch, address_in=0x1000, rdata 0x11111111..0x44444444 -> mem_addr_out 0x1000,0x1004,0x1008,0x100C in cycles 1-4; data_valid_out in cycle 6 only; data_out=0x44444444_33333333_22222222_11111111; halt_en_out=1 in cycles 1-6.
- gnt held low 3 cycles on the second request -> mem_req_out=1 and mem_addr_out=0x1004 stable for 4 cycles; final data correct; data_valid_out delayed 3 cycles.
- All grants immediate, rvalids delayed 5 cycles then bursty -> WAIT_RSP held with mem_req_out=0; words stored in request order; single valid pulse.
- Start asserted during REQ, plus a spurious rvalid while IDLE -> no extra requests; data_out unchanged by the spurious rvalid.
- address_in=0xFFFFFFFA -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- rst_n pulsed after 2 responses -> all outputs 0 next cycle; late rvalids ignored; a following fetch completes with correct data.

Source files
------------

// File: rtl/riscv_aes_fetch_if.sv
// riscv_aes_fetch_if: PULP req/gnt/rvalid read port between the AES fetch unit and data memory.
interface riscv_aes_fetch_if;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_gnt_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  modport master(output mem_req_out, mem_addr_out, input mem_gnt_in, mem_rvalid_in, mem_rdata_in);
  modport slave(input mem_req_out, mem_addr_out, output mem_gnt_in, mem_rvalid_in, mem_rdata_in);
endinterface

// File: rtl/riscv_aes_fetch.sv
// riscv_aes_fetch: halts the core, reads NUM_WORDS sequential words and hands the block to the AES core.
module riscv_aes_fetch #(
  parameter int NUM_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_aes_fetch_in,
  input  logic [31:0]               address_in,
  riscv_aes_fetch_if.master         bus,
  output logic                      halt_en_out,
  output logic                      data_valid_out,
  output logic [32*NUM_WORDS-1:0]   data_out
);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_RSP = 2'd2, DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_WORDS);
  logic [1:0]    state, state_nxt;
  logic [31:0]   base;
  logic [CW-1:0] req_cnt, rsp_cnt;
  logic          grant, capture, last_rsp;
  assign grant    = state == REQ && bus.mem_gnt_in;
  assign capture  = (state == REQ || state == WAIT_RSP) && bus.mem_rvalid_in && rsp_cnt != FULL;
  assign last_rsp = capture && rsp_cnt == LAST;
  // request side depends only on registered state, never on the grant
  assign bus.mem_req_out  = state == REQ;
  assign bus.mem_addr_out = base + {{(30-CW){1'b0}}, req_cnt, 2'b00};
  assign halt_en_out      = state != IDLE;
  assign data_valid_out   = state == DONE;
  assign state_nxt = last_rsp          ? DONE :
                     state == IDLE     ? (start_aes_fetch_in ? REQ : IDLE) :
                     state == REQ      ? (grant && req_cnt == LAST ? WAIT_RSP : REQ) :
                     state == WAIT_RSP ? WAIT_RSP : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_aes_fetch_in) begin
        base    <= {address_in[31:2], 2'b00};
        req_cnt <= '0;
        rsp_cnt <= '0;
      end
      if (grant) req_cnt <= req_cnt + 1'b1;
      if (capture) begin
        data_out[rsp_cnt*32 +: 32] <= bus.mem_rdata_in;
        rsp_cnt                    <= rsp_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_riscv_aes_fetch.sv
// tb_riscv_aes_fetch: directed tests of the AES fetch unit against a small in-order memory model.
module tb_riscv_aes_fetch;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] addr_in = 0;
  logic halt, valid;
  logic [32*N-1:0] data;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  riscv_aes_fetch_if bus();
  riscv_aes_fetch #(.NUM_WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_aes_fetch_in(start), .address_in(addr_in),
    .bus(bus.master), .halt_en_out(halt), .data_valid_out(valid), .data_out(data)
  );
  // memory model: grants unless stalled, returns data in order `extra` cycles late
  typedef struct { logic [31:0] d; int due; } rsp_t;
  rsp_t q[$];
  int cyc = 0, mode = 0, extra = 0, stall_left = 0;
  logic [31:0] stall_addr = 0, last_addr = 0;
  logic last_grant = 0, spur = 0;
  function automatic logic [31:0] word_for(input logic [31:0] a);
    return mode == 0 ? ({30'b0, a[3:2]} + 32'd1) * 32'h11111111 : a ^ 32'h5A5A5A5A;
  endfunction
  initial begin
    bus.mem_gnt_in = 0; bus.mem_rvalid_in = 0; bus.mem_rdata_in = 0;
    forever begin
      @(posedge clk); #1; cyc++;
      if (last_grant) q.push_back('{word_for(last_addr), cyc + extra});
      bus.mem_gnt_in = 0;
      if (bus.mem_req_out) begin
        if (bus.mem_addr_out == stall_addr && stall_left > 0) stall_left--;
        else bus.mem_gnt_in = 1;
      end
      bus.mem_rvalid_in = 0; bus.mem_rdata_in = 0;
      if (spur) begin
        bus.mem_rvalid_in = 1; bus.mem_rdata_in = 32'hDEADBEEF;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        bus.mem_rvalid_in = 1; bus.mem_rdata_in = q.pop_front().d;
      end
      last_grant = bus.mem_req_out && bus.mem_gnt_in;
      last_addr  = bus.mem_addr_out;
    end
  end
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic test_reset();
    tick(); tick();
    compared += 5;
    if (bus.mem_req_out !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b want 0", bus.mem_req_out); end
    if (bus.mem_addr_out !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr_out); end
    if (halt !== 1'b0) begin mismatched++; $display("FAIL reset_halt: got %b want 0", halt); end
    if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (data !== '0) begin mismatched++; $display("FAIL reset_data: got %h want 0", data); end
    rst_n = 1; tick();
  endtask
  task automatic test_zero_wait();
    mode = 0; extra = 0; addr_in = 32'h1000; start = 1;
    for (int c = 1; c <= 7; c++) begin
      tick(); start = 0;
      compared += 3;
      if (bus.mem_req_out !== (c <= 4)) begin mismatched++; $display("FAIL zw_req c%0d: got %b want %b", c, bus.mem_req_out, c <= 4); end
      if (valid !== (c == 6)) begin mismatched++; $display("FAIL zw_valid c%0d: got %b want %b", c, valid, c == 6); end
      if (halt !== (c <= 6)) begin mismatched++; $display("FAIL zw_halt c%0d: got %b want %b", c, halt, c <= 6); end
      if (c <= 4) begin
        compared++;
        if (bus.mem_addr_out !== 32'h1000 + 32'(4 * (c - 1))) begin mismatched++; $display("FAIL zw_addr c%0d: got %h want %h", c, bus.mem_addr_out, 32'h1000 + 32'(4 * (c - 1))); end
      end
      if (c == 6) begin
        compared++;
        if (data !== 128'h44444444_33333333_22222222_11111111) begin mismatched++; $display("FAIL zw_data: got %h", data); end
      end
    end
  endtask
  task automatic test_gnt_stall();
    mode = 1; addr_in = 32'h2000; stall_addr = 32'h2004; stall_left = 3; start = 1;
    for (int c = 1; c <= 10; c++) begin
      tick(); start = 0;
      compared += 2;
      if (valid !== (c == 9)) begin mismatched++; $display("FAIL st_valid c%0d: got %b want %b", c, valid, c == 9); end
      if (halt !== (c <= 9)) begin mismatched++; $display("FAIL st_halt c%0d: got %b want %b", c, halt, c <= 9); end
      if (c >= 2 && c <= 5) begin
        compared += 2;
        if (bus.mem_req_out !== 1'b1) begin mismatched++; $display("FAIL st_req c%0d: got %b want 1", c, bus.mem_req_out); end
        if (bus.mem_addr_out !== 32'h2004) begin mismatched++; $display("FAIL st_addr c%0d: got %h want 00002004", c, bus.mem_addr_out); end
      end
      if (c == 9) begin
        compared++;
        if (data !== 128'h5A5A7A56_5A5A7A52_5A5A7A5E_5A5A7A5A) begin mismatched++; $display("FAIL st_data: got %h", data); end
      end
    end
  endtask
  task automatic test_delayed_rsp();
    mode = 1; extra = 5; addr_in = 32'h3000; start = 1;
    for (int c = 1; c <= 12; c++) begin
      tick(); start = 0;
      compared += 3;
      if (valid !== (c == 11)) begin mismatched++; $display("FAIL dr_valid c%0d: got %b want %b", c, valid, c == 11); end
      if (halt !== (c <= 11)) begin mismatched++; $display("FAIL dr_halt c%0d: got %b want %b", c, halt, c <= 11); end
      if (bus.mem_req_out !== (c <= 4)) begin mismatched++; $display("FAIL dr_req c%0d: got %b want %b", c, bus.mem_req_out, c <= 4); end
      if (c == 11) begin
        compared++;
        if (data !== 128'h5A5A6A56_5A5A6A52_5A5A6A5E_5A5A6A5A) begin mismatched++; $display("FAIL dr_data: got %h", data); end
      end
    end
    extra = 0;
  endtask
  task automatic test_ignore();
    int grants = 0, pulses = 0;
    spur = 1; tick(); spur = 0; tick(); tick();
    compared += 2;
    if (data !== 128'h5A5A6A56_5A5A6A52_5A5A6A5E_5A5A6A5A) begin mismatched++; $display("FAIL ig_spur_data: got %h", data); end
    if (halt !== 1'b0) begin mismatched++; $display("FAIL ig_spur_halt: got %b want 0", halt); end
    mode = 0; addr_in = 32'h1000; start = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 3) start = 0;
      grants += int'(bus.mem_req_out && bus.mem_gnt_in);
      pulses += int'(valid);
    end
    compared += 4;
    if (grants !== 4) begin mismatched++; $display("FAIL ig_grants: got %0d want 4", grants); end
    if (pulses !== 1) begin mismatched++; $display("FAIL ig_pulses: got %0d want 1", pulses); end
    if (halt !== 1'b0) begin mismatched++; $display("FAIL ig_halt: got %b want 0", halt); end
    if (data !== 128'h44444444_33333333_22222222_11111111) begin mismatched++; $display("FAIL ig_data: got %h", data); end
  endtask
  task automatic test_addr_wrap();
    logic [31:0] exp_a [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    mode = 1; addr_in = 32'hFFFFFFFA; start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick(); start = 0;
      if (c <= 4) begin
        compared++;
        if (bus.mem_addr_out !== exp_a[c-1]) begin mismatched++; $display("FAIL wr_addr c%0d: got %h want %h", c, bus.mem_addr_out, exp_a[c-1]); end
      end
    end
    compared += 2;
    if (valid !== 1'b1) begin mismatched++; $display("FAIL wr_valid: got %b want 1", valid); end
    if (data !== 128'h5A5A5A5E_5A5A5A5A_A5A5A5A6_A5A5A5A2) begin mismatched++; $display("FAIL wr_data: got %h", data); end
    tick();
  endtask
  task automatic test_reset_mid();
    mode = 0; addr_in = 32'h1000; start = 1;
    tick(); start = 0; tick(); tick(); tick();
    compared++;
    if (data[63:0] !== 64'h22222222_11111111) begin mismatched++; $display("FAIL rm_partial: got %h", data[63:0]); end
    rst_n = 0; #1;
    compared += 5;
    if (bus.mem_req_out !== 1'b0) begin mismatched++; $display("FAIL rm_req: got %b want 0", bus.mem_req_out); end
    if (bus.mem_addr_out !== 32'h0) begin mismatched++; $display("FAIL rm_addr: got %h want 0", bus.mem_addr_out); end
    if (halt !== 1'b0) begin mismatched++; $display("FAIL rm_halt: got %b want 0", halt); end
    if (valid !== 1'b0) begin mismatched++; $display("FAIL rm_valid: got %b want 0", valid); end
    if (data !== '0) begin mismatched++; $display("FAIL rm_data: got %h want 0", data); end
    tick(); rst_n = 1;
    for (int c = 0; c < 5; c++) tick();
    compared += 2;
    if (data !== '0) begin mismatched++; $display("FAIL rm_late_data: got %h want 0", data); end
    if (halt !== 1'b0) begin mismatched++; $display("FAIL rm_late_halt: got %b want 0", halt); end
    mode = 1; addr_in = 32'h2000; start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick(); start = 0;
    end
    compared += 2;
    if (valid !== 1'b1) begin mismatched++; $display("FAIL rm_refetch_valid: got %b want 1", valid); end
    if (data !== 128'h5A5A7A56_5A5A7A52_5A5A7A5E_5A5A7A5A) begin mismatched++; $display("FAIL rm_refetch_data: got %h", data); end
  endtask
  initial begin
    test_reset();
    test_zero_wait();
    tick();
    test_gnt_stall();
    tick();
    test_delayed_rsp();
    test_ignore();
    tick();
    test_addr_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
